// File: rtl/common_types_pkg.sv
// common_types_pkg: shared word type plus the I/D request arbiter's state, request and mode types.
package common_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RELEASE} arb_state_t;

    typedef struct packed {
        logic       read;
        logic [1:0] write;
        word_t      addr;
        word_t      store;
    } arb_req_t;

    localparam int ARB_RR      = 0;
    localparam int ARB_FIXED_D = 1;

endpackage

// File: rtl/axi_request_arbiter.sv
// axi_request_arbiter: shares one AXI controller port between I-fetch and D-memory requesters,
// one registered transaction in flight, round-robin or D-priority with a starvation guard.
module axi_request_arbiter
    import common_types_pkg::*;
#(
    parameter int ARB_MODE     = ARB_RR,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_read,
    input  word_t       i_addr,
    output logic        i_ready,
    output word_t       i_load,
    input  logic        d_read,
    input  logic [1:0]  d_write,
    input  word_t       d_addr,
    input  word_t       d_store,
    output logic        d_ready,
    output word_t       d_load,
    output logic        m_read,
    output logic [1:0]  m_write,
    output word_t       m_addr,
    output word_t       m_store,
    output logic        m_done,
    input  logic        m_ready,
    input  word_t       m_load
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t state, state_next;
    arb_req_t   req, req_next;
    logic       last_d, last_d_next;
    logic [3:0] starve, starve_next;
    logic       req_i, req_d, pick_d, busy;

    always_comb begin
        req_i       = i_read;
        req_d       = d_read | (|d_write);
        pick_d      = req_d & (!req_i | (ARB_MODE == ARB_RR ? !last_d : starve != LIMIT));
        busy        = state == BUSY_I || state == BUSY_D;
        state_next  = state;
        req_next    = req;
        last_d_next = last_d;
        starve_next = starve;
        case (state)
            IDLE: if (req_i | req_d) begin
                state_next     = pick_d ? BUSY_D : BUSY_I;
                last_d_next    = pick_d;
                starve_next    = pick_d & i_read ? (starve == LIMIT ? starve : starve + 4'd1) : 4'd0;
                // a D read takes precedence over a simultaneous store size
                req_next.read  = !pick_d | d_read;
                req_next.write = pick_d & !d_read ? d_write : 2'b00;
                req_next.addr  = pick_d ? d_addr : i_addr;
                req_next.store = pick_d & !d_read ? d_store : req.store;
            end
            BUSY_I, BUSY_D: if (m_ready) begin
                state_next     = RELEASE;
                req_next.read  = 1'b0;
                req_next.write = 2'b00;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state  <= IDLE;
            req    <= '0;
            last_d <= 1'b1;
            starve <= 4'd0;
        end else begin
            state  <= state_next;
            req    <= req_next;
            last_d <= last_d_next;
            starve <= starve_next;
        end
    end

    assign m_read  = req.read;
    assign m_write = req.write;
    assign m_addr  = req.addr;
    assign m_store = req.store;
    assign m_done  = busy & m_ready;
    assign i_ready = state == BUSY_I && m_ready;
    assign d_ready = state == BUSY_D && m_ready;
    assign i_load  = m_load;
    assign d_load  = m_load;

endmodule

// File: tb/tb_axi_request_arbiter.sv
// tb_axi_request_arbiter: scoreboard bench driving a round-robin and a D-priority arbiter from shared
// requesters, each with its own 3-cycle controller model.
module tb_axi_request_arbiter;
    import common_types_pkg::*;

    typedef struct { logic read; logic [1:0] write; word_t addr; word_t store; } req_e;
    typedef struct { logic is_d; word_t load; } cmp_e;

    logic clk = 0, nrst = 0;
    logic i_read = 0, d_read = 0;
    logic [1:0] d_write = 0;
    word_t i_addr = 0, d_addr = 0, d_store = 0, ld = 0;

    logic i_ready0, d_ready0, m_read0, m_done0, m_ready0 = 0;
    logic i_ready1, d_ready1, m_read1, m_done1, m_ready1 = 0;
    logic [1:0] m_write0, m_write1;
    word_t i_load0, d_load0, m_addr0, m_store0, i_load1, d_load1, m_addr1, m_store1;
    int cnt0 = 0, cnt1 = 0;
    int checks = 0, errors = 0;
    logic prev0 = 0, prev1 = 0;
    req_e rq0[$], rq1[$];
    cmp_e cq0[$], cq1[$];

    always #5 clk = ~clk;

    axi_request_arbiter #(.ARB_MODE(ARB_RR), .STARVE_LIMIT(4)) dut0 (
        .clk(clk), .nrst(nrst),
        .i_read(i_read), .i_addr(i_addr), .i_ready(i_ready0), .i_load(i_load0),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_store(d_store),
        .d_ready(d_ready0), .d_load(d_load0),
        .m_read(m_read0), .m_write(m_write0), .m_addr(m_addr0), .m_store(m_store0),
        .m_done(m_done0), .m_ready(m_ready0), .m_load(ld)
    );

    axi_request_arbiter #(.ARB_MODE(ARB_FIXED_D), .STARVE_LIMIT(4)) dut1 (
        .clk(clk), .nrst(nrst),
        .i_read(i_read), .i_addr(i_addr), .i_ready(i_ready1), .i_load(i_load1),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_store(d_store),
        .d_ready(d_ready1), .d_load(d_load1),
        .m_read(m_read1), .m_write(m_write1), .m_addr(m_addr1), .m_store(m_store1),
        .m_done(m_done1), .m_ready(m_ready1), .m_load(ld)
    );

    // controller models: result valid 3 cycles after a request appears, held until m_done
    always @(posedge clk)
        if (!nrst) begin m_ready0 <= 0; cnt0 <= 0; end
        else if (m_ready0) begin if (m_done0) m_ready0 <= 0; end
        else if (m_read0 | (|m_write0)) begin
            if (cnt0 == 2) begin m_ready0 <= 1; cnt0 <= 0; end else cnt0 <= cnt0 + 1;
        end

    always @(posedge clk)
        if (!nrst) begin m_ready1 <= 0; cnt1 <= 0; end
        else if (m_ready1) begin if (m_done1) m_ready1 <= 0; end
        else if (m_read1 | (|m_write1)) begin
            if (cnt1 == 2) begin m_ready1 <= 1; cnt1 <= 0; end else cnt1 <= cnt1 + 1;
        end

    task automatic mon(input int k, input logic rd, input logic [1:0] wr, input word_t ad, st,
                       input logic ir, dr, dn, input word_t il, dl, input logic prev, output logic nxt);
        req_e e;
        cmp_e c;
        logic got;
        nxt = rd | (|wr);
        if (nxt && !prev) begin
            checks++;
            got = k == 0 ? rq0.size() > 0 : rq1.size() > 0;
            if (!got) begin
                errors++;
                $display("FAIL req%0d: unexpected request read=%b write=%b addr=%h", k, rd, wr, ad);
            end else begin
                if (k == 0) e = rq0.pop_front(); else e = rq1.pop_front();
                if (rd !== e.read || wr !== e.write || ad !== e.addr || (e.write != 0 && st !== e.store)) begin
                    errors++;
                    $display("FAIL req%0d: got read=%b write=%b addr=%h store=%h, want read=%b write=%b addr=%h store=%h",
                             k, rd, wr, ad, st, e.read, e.write, e.addr, e.store);
                end
            end
        end
        if (ir | dr | dn) begin
            checks++;
            got = k == 0 ? cq0.size() > 0 : cq1.size() > 0;
            if (!got) begin
                errors++;
                $display("FAIL cmp%0d: unexpected completion i_ready=%b d_ready=%b m_done=%b", k, ir, dr, dn);
            end else begin
                if (k == 0) c = cq0.pop_front(); else c = cq1.pop_front();
                if (ir !== !c.is_d || dr !== c.is_d || dn !== 1'b1 || (c.is_d ? dl : il) !== c.load) begin
                    errors++;
                    $display("FAIL cmp%0d: got i_ready=%b d_ready=%b m_done=%b i_load=%h d_load=%h, want is_d=%b load=%h",
                             k, ir, dr, dn, il, dl, c.is_d, c.load);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, m_read0, m_write0, m_addr0, m_store0, i_ready0, d_ready0, m_done0, i_load0, d_load0, prev0, prev0);
        mon(1, m_read1, m_write1, m_addr1, m_store1, i_ready1, d_ready1, m_done1, i_load1, d_load1, prev1, prev1);
    end

    task automatic chk(input string name, input logic [71:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic is_d, rd, input logic [1:0] wr, input word_t ad, st, input logic cmp);
        req_e e;
        cmp_e c;
        e.read = rd; e.write = wr; e.addr = ad; e.store = st;
        c.is_d = is_d; c.load = ld;
        if (k == 0) rq0.push_back(e); else rq1.push_back(e);
        if (cmp) begin
            if (k == 0) cq0.push_back(c); else cq1.push_back(c);
        end
    endtask

    task automatic wait_rdy(input string name, input logic want_d, output int n);
        n = 0;
        repeat (50) begin
            @(negedge clk);
            n++;
            if (want_d ? d_ready0 : i_ready0) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: no ready within 50 cycles", name);
        n = -1;
    endtask

    task automatic wait_n(input string name, input int want);
        int got = 0;
        repeat (400) begin
            @(negedge clk);
            if (i_ready0 | d_ready0) got++;
            if (got == want) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: %0d of %0d completions within 400 cycles", name, got, want);
    endtask

    task automatic pulse_rst();
        @(negedge clk) nrst = 0;
        @(negedge clk) nrst = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst0", {m_read0, m_write0, m_addr0, m_store0, i_ready0, d_ready0, m_done0}, 0);
        chk("rst1", {m_read1, m_write1, m_addr1, m_store1, i_ready1, d_ready1, m_done1}, 0);
        nrst = 1;

        // I-only fetch
        @(negedge clk);
        i_addr = 32'h100; i_read = 1; ld = 32'hDEADBEEF;
        for (int k = 0; k < 2; k++) push(k, 0, 1, 2'b00, 32'h100, 0, 1);
        @(posedge clk) #1;
        chk("t1_req", {m_read0, m_addr0, m_read1, m_addr1}, {1'b1, 32'h100, 1'b1, 32'h100});
        wait_rdy("t1_ready", 0, n);
        i_read = 0;
        chk("t1_latency", n, 4);
        @(negedge clk);
        chk("t1_release", {i_ready0, m_read0, m_done0}, 0);

        // D word store
        repeat (2) @(negedge clk);
        d_addr = 32'h200; d_store = 32'h12345678; d_write = 2'b11; ld = 32'h0BADF00D;
        for (int k = 0; k < 2; k++) push(k, 1, 0, 2'b11, 32'h200, 32'h12345678, 1);
        @(posedge clk) #1;
        chk("t2_req", {m_read0, m_write0, m_store0}, {1'b0, 2'b11, 32'h12345678});
        wait_rdy("t2_ready", 1, n);
        d_write = 0;
        @(negedge clk);
        chk("t2_clear", {m_write0, m_write1, d_ready0}, 0);

        // D read with a simultaneous store size: read wins
        repeat (2) @(negedge clk);
        d_addr = 32'h300; d_read = 1; d_write = 2'b11; ld = 32'h600DCAFE;
        for (int k = 0; k < 2; k++) push(k, 1, 1, 2'b00, 32'h300, 0, 1);
        wait_rdy("t5_ready", 1, n);
        d_read = 0; d_write = 0;
        repeat (3) @(negedge clk);

        // both requesting continuously: RR alternates I,D; fixed-D gives D,D,D,D,I
        pulse_rst();
        ld = 32'hCAFE0000;
        for (int j = 0; j < 10; j++) begin
            if (j % 2 == 0) push(0, 0, 1, 2'b00, 32'h1000, 0, 1);
            else push(0, 1, 1, 2'b00, 32'h2000, 0, 1);
            if (j % 5 == 4) push(1, 0, 1, 2'b00, 32'h1000, 0, 1);
            else push(1, 1, 1, 2'b00, 32'h2000, 0, 1);
        end
        i_addr = 32'h1000; d_addr = 32'h2000; i_read = 1; d_read = 1;
        wait_n("t34_stream", 10);
        i_read = 0; d_read = 0;
        repeat (3) @(negedge clk);

        // reset during BUSY_D with no result yet
        d_addr = 32'h400; d_store = 32'h55; d_write = 2'b11; ld = 32'h13572468;
        for (int k = 0; k < 2; k++) push(k, 1, 0, 2'b11, 32'h400, 32'h55, 0);
        n = 0;
        while (m_write0 == 2'b00 && n < 10) begin @(negedge clk); n++; end
        chk("t6_grant", {m_write0, m_ready0}, {2'b11, 1'b0});
        nrst = 0; i_addr = 32'h1000; i_read = 1;
        push(0, 0, 1, 2'b00, 32'h1000, 0, 1);
        push(0, 1, 0, 2'b11, 32'h400, 32'h55, 1);
        push(1, 1, 0, 2'b11, 32'h400, 32'h55, 1);
        push(1, 1, 0, 2'b11, 32'h400, 32'h55, 1);
        @(posedge clk) #1;
        chk("t6_rst0", {m_read0, m_write0, m_addr0, m_store0, m_done0, d_ready0}, 0);
        chk("t6_rst1", {m_read1, m_write1, m_addr1, m_store1, m_done1, d_ready1}, 0);
        @(negedge clk) nrst = 1;
        wait_n("t6_after", 2);
        i_read = 0; d_write = 0;

        repeat (5) @(negedge clk);
        chk("rq0_empty", rq0.size(), 0);
        chk("rq1_empty", rq1.size(), 0);
        chk("cq0_empty", cq0.size(), 0);
        chk("cq1_empty", cq1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
